dffr_pipe_hs: RTL
=================

// Module: dffr_pipe_hs
// PURPOSE
//  Parametrised elastic pipeline register: STAGES chained registers carrying WIDTH-bit data with valid/ready handshake.
//  Each stage has a skid entry, so ready is registered and never combinational end to end.
//  Adds stall back-pressure, flush-to-bubble and an occupancy count, none of which a plain enable/reset flop provides.
//  Used between CPU pipeline stages (IF/ID, ID/EX, ...) and on memory request/response paths.
// PARAMETERS
//  WIDTH     1  payload width in bits; must be >= 1
//  STAGES    1  register stages, input to output; must be >= 1
//  RST_DATA  0  1: data registers clear to 0 on r; 0: only valid bits clear, data registers are not reset
// PORTS
//  clk        in   1                    rising-edge clock
//  r          in   1                    synchronous active-high reset
//  flush      in   1                    synchronous clear of every held entry (pipeline kill)
//  in_valid   in   1                    upstream payload valid
//  in_ready   out  1                    stage 0 can accept; registered
//  in_data    in   WIDTH                upstream payload
//  out_valid  out  1                    last stage holds a payload
//  out_ready  in   1                    downstream accepts
//  out_data   out  WIDTH                last-stage payload
//  count      out  clog2(2*STAGES+1)    entries currently held across all stages
// BEHAVIOUR
//  - Reset (r high at posedge): all valid and skid bits become 0.
//    After reset: out_valid=0, in_ready=1, count=0. out_data=0 only when RST_DATA=1.
//  - Priority: r > flush > normal operation.
//  - flush: all valid bits are 0 next cycle. An in_valid&in_ready beat in the flush cycle is dropped.
//    Data registers are not cleared by flush. in_ready=1 in the cycle after flush.
//  - Transfer rule: a beat moves when valid&ready are both high at posedge.
//    Once a producer raises valid it holds valid and data stable until ready.
//  - Each stage has a main entry (mv, md) and a skid entry (sv, sd).
//    Stage ready_out = !sv (registered).
//    Stage output = main entry.
//  - Per-stage update, with d_ok = downstream ready and u_fire = upstream valid & stage ready_out:
//      main empty or d_ok:  if sv, main <- skid and sv <- 0; else main <- input when u_fire, mv <- u_fire.
//      main full and !d_ok: if u_fire, skid <- input and sv <- 1.
//    A stage never accepts when sv=1, so it never overflows.
//  - Latency: a beat accepted at edge N is on out_valid after edge N+STAGES-1 when nothing stalls, i.e. STAGES cycles.
//    Throughput: 1 beat/cycle with out_ready held high.
//  - Stall: with out_ready=0, the pipe absorbs up to 2*STAGES beats before in_ready falls.
//    in_ready falls one cycle after stage 0 skid fills.
//  - Ordering: strictly FIFO. No beat is duplicated or lost except by flush or r.
//  - count: +1 on an input fire, -1 on an output fire, unchanged when both occur. Cleared by r or flush.
//    Range 0..2*STAGES; must never wrap.
//  - out_ready may toggle every cycle; payload order and count stay exact.
//  - Reset or flush while stalled: the pipe is empty next cycle and no stale out_valid appears.
// STRUCTURE
//  - Sub-module skid_stage (WIDTH, RST_DATA): one main+skid stage with valid/ready on both sides.
//    The top is a generate chain of STAGES skid_stage instances plus the count register.
//  - Shared package/include ff_pkg: clog2 constant function and the width expression for count.
//  - r and flush fan out to every stage. flush acts as a reset of the valid bits only.
// TESTING
//  1. r=1 for 2 cycles -> out_valid=0, in_ready=1, count=0. With RST_DATA=1, out_data=0.
//  2. STAGES=3, WIDTH=8, out_ready=1, stream 0x01..0x0A back-to-back
//     -> first out_valid 3 cycles after first accept, then 0x01..0x0A on consecutive cycles.
//  3. STAGES=3, out_ready=0, in_valid=1 continuously -> exactly 6 beats accepted, then in_ready=0.
//     count=6. Release out_ready -> 6 beats out in order, count returns to 0.
//  4. Random 50% out_ready and 50% in_valid, 1000 beats, STAGES=2
//     -> scoreboard: all beats exactly once, in order. count equals scoreboard depth every cycle.
//  5. Pipe holding 4 beats, flush=1 with in_valid=1 (0xAA) -> next cycle out_valid=0, count=0, 0xAA never appears.
//  6. r asserted mid-stall with flush=1 in the same cycle -> reset values next cycle, and no output until new input.

Source files
------------

// File: rtl/ff_pkg.sv
// Shared helpers for the elastic pipeline register: a ceiling log2 and the
// width of the occupancy counter.
package ff_pkg;

  // Number of bits needed to represent values 0 .. value-1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  // Occupancy ranges over 0 .. 2*stages (a main and a skid entry per stage).
  function automatic int count_w(input int stages);
    return clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/skid_stage.sv
// One elastic stage: a main entry that drives the downstream side and a skid
// entry that catches the beat arriving in the cycle the downstream stalls.
// Handshake: a beat moves on a rising edge where valid and ready are both
// high; a producer holds valid and data stable until it sees ready.
// up_ready comes straight from the skid flag, so ready is always registered.
module skid_stage
  import ff_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter bit RST_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             r,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data
);

  logic             mv_q, mv_d;
  logic             sv_q, sv_d;
  logic [WIDTH-1:0] md_q, md_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             u_fire;

  assign up_ready = ~sv_q;
  assign dn_valid = mv_q;
  assign dn_data  = md_q;

  // Next-state: refill main from skid first, otherwise from the input; park an
  // incoming beat in the skid only while main is blocked downstream.
  always_comb begin
    u_fire = up_valid & ~sv_q;
    mv_d   = mv_q;
    sv_d   = sv_q;
    md_d   = md_q;
    sd_d   = sd_q;
    if (!mv_q || dn_ready) begin
      if (sv_q) begin
        mv_d = 1'b1;
        md_d = sd_q;
        sv_d = 1'b0;
      end else begin
        mv_d = u_fire;
        if (u_fire) md_d = up_data;
      end
    end else if (u_fire) begin
      sv_d = 1'b1;
      sd_d = up_data;
    end
  end

  // Valid bits: reset and flush both empty the stage.
  always_ff @(posedge clk) begin
    if (r || flush) begin
      mv_q <= 1'b0;
      sv_q <= 1'b0;
    end else begin
      mv_q <= mv_d;
      sv_q <= sv_d;
    end
  end

  // Data registers: cleared by reset only when requested, never by flush.
  generate
    if (RST_DATA) begin : g_data_rst
      always_ff @(posedge clk) begin
        if (r) begin
          md_q <= '0;
          sd_q <= '0;
        end else begin
          md_q <= md_d;
          sd_q <= sd_d;
        end
      end
    end else begin : g_data_norst
      always_ff @(posedge clk) begin
        md_q <= md_d;
        sd_q <= sd_d;
      end
    end
  endgenerate

endmodule

// File: rtl/dffr_pipe_hs.sv
// Elastic pipeline register: STAGES skid stages chained input to output, with
// flush-to-bubble and an occupancy count of the beats held across all stages.
// Handshake: a beat moves on a rising edge where valid and ready are both
// high; a producer holds valid and data stable until it sees ready.
module dffr_pipe_hs
  import ff_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int STAGES   = 1,
  parameter bit RST_DATA = 1'b0
) (
  input  logic                          clk,
  input  logic                          r,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [count_w(STAGES)-1:0]    count
);

  localparam int CW = count_w(STAGES);

  // Link i connects stage i-1 (or the input port) to stage i (or the output).
  logic             stage_valid [STAGES+1];
  logic             stage_ready [STAGES+1];
  logic [WIDTH-1:0] stage_data  [STAGES+1];

  logic [CW-1:0]    count_q, count_d;
  logic             in_fire, out_fire;

  assign stage_valid[0]      = in_valid;
  assign stage_data[0]       = in_data;
  assign in_ready            = stage_ready[0];
  assign out_valid           = stage_valid[STAGES];
  assign out_data            = stage_data[STAGES];
  assign stage_ready[STAGES] = out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      skid_stage #(
        .WIDTH    (WIDTH),
        .RST_DATA (RST_DATA)
      ) u_stage (
        .clk      (clk),
        .r        (r),
        .flush    (flush),
        .up_valid (stage_valid[gi]),
        .up_ready (stage_ready[gi]),
        .up_data  (stage_data[gi]),
        .dn_valid (stage_valid[gi+1]),
        .dn_ready (stage_ready[gi+1]),
        .dn_data  (stage_data[gi+1])
      );
    end
  endgenerate

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign count    = count_q;

  // Occupancy: +1 per accepted beat, -1 per delivered beat, net zero for both.
  always_comb begin
    count_d = count_q;
    if (in_fire && !out_fire) count_d = count_q + CW'(1);
    else if (!in_fire && out_fire) count_d = count_q - CW'(1);
  end

  // Occupancy register: cleared together with the valid bits.
  always_ff @(posedge clk) begin
    if (r || flush) count_q <= '0;
    else            count_q <= count_d;
  end

endmodule
